// File: rtl/sdp_cfg_triosy_seq.sv
// sdp_cfg_triosy_seq: completion sequencer for the SDP configuration triosy channels.
// After a start, issues each selected channel's lz strobe under stall control,
// records per-channel completion, and pulses done once the set is exhausted.
// Optional feature macro: SDP_TRIOSY_SEQ_PARALLEL_EN (all pending channels issue together).
module sdp_cfg_triosy_seq #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] triosy_lz,
  output logic [NUM_CH-1:0] ch_bawt,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [NUM_CH-1:0]   r_pending;
  logic                r_busy;
  logic                r_done;
  logic [NUM_CH-1:0]   r_bawt;
  logic [DROP_W-1:0]   r_drop;

  logic [NUM_CH-1:0]   w_sel;
  logic [NUM_CH-1:0]   w_rem;
  logic                w_issue;

  // Channel set released by one unstalled ISSUE cycle.
`ifdef SDP_TRIOSY_SEQ_PARALLEL_EN
  assign w_sel = r_pending;
`else
  assign w_sel = r_pending & (~r_pending + NUM_CH'(1));
`endif

  assign w_rem     = r_pending & ~w_sel;
  assign w_issue   = (r_state == ISSUE) && !stall;
  assign triosy_lz = w_issue ? w_sel : '0;

  assign busy     = r_busy;
  assign done     = r_done;
  assign ch_bawt  = r_bawt;
  assign drop_cnt = r_drop;

  // Sequencer state, completion flags and dropped-start counter.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bawt    <= '0;
      r_drop    <= '0;
    end else begin
      r_done <= 1'b0;

      // Starts arriving while a sequence is running (including DONE) are dropped.
      if (start && r_busy && (r_drop != {DROP_W{1'b1}})) begin
        r_drop <= r_drop + DROP_W'(1);
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_pending <= ch_mask;
            r_bawt    <= '0;
            r_busy    <= 1'b1;
            if (ch_mask != '0) begin
              r_state <= ISSUE;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (w_issue) begin
            r_pending <= w_rem;
            r_bawt    <= r_bawt | w_sel;
            if (w_rem == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_pending <= '0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sdp_cfg_triosy_seq.md
# sdp_cfg_triosy_seq

Completion sequencer for the SDP core's configuration-resource triosy channels. After a layer's configuration has been consumed, it issues each selected channel's triosy `lz` completion strobe under core stall control and tracks per-channel completion. It reports frame-level done to the SDP core FSM. It sits between the core control FSM and the per-resource triosy wait datapaths, such as the `cfg_mul_shift_value` channel.

## Interface
Parameters:
- `NUM_CH`, default 8: number of triosy channels (1..32).
- `DROP_W`, default 8: width of the saturating dropped-start counter.

Ports:
- `nvdla_core_clk`, input, 1: core clock; all state changes on its rising edge.
- `nvdla_core_rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: one-cycle request to begin a completion sequence.
- `ch_mask`, input, `NUM_CH`: channels to complete; sampled only when `start` is accepted.
- `stall`, input, 1: core stall (bdwt-equivalent); while high, no `lz` is issued.
- `busy`, output, 1: sequence in progress.
- `done`, output, 1: one-cycle pulse after the last selected channel has issued.
- `triosy_lz`, output, `NUM_CH`: per-channel completion strobe (combinational from state and `stall`).
- `ch_bawt`, output, `NUM_CH`: per-channel "completed" flag (registered, sticky until the next accepted start).
- `drop_cnt`, output, `DROP_W`: saturating count of starts ignored while busy.

## Operation
- States: IDLE, ISSUE, DONE.
- Reset value of every registered output and state:
  - state = IDLE, pending = 0.
  - `busy` = 0, `done` = 0, `triosy_lz` = 0, `ch_bawt` = 0, `drop_cnt` = 0.
- IDLE:
  - `start` = 1 is accepted: pending <= `ch_mask`, `ch_bawt` <= 0.
  - Next state is ISSUE if `ch_mask` ≠ 0; DONE if `ch_mask` = 0.
- ISSUE:
  - Select = the lowest set bit of pending (serial mode).
  - If `stall` = 0: `triosy_lz` = select, pending clears that bit, and `ch_bawt` sets that bit at the edge.
  - If `stall` = 1: `triosy_lz` = 0 and nothing changes.
  - When the issue empties pending, next state is DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `busy` = 1 in ISSUE and DONE, 0 in IDLE.
- `start` while `busy` = 1 is ignored and `drop_cnt` increments, saturating at all-ones. A start in the DONE cycle is also ignored.
- `ch_mask` bits at or above `NUM_CH` do not exist. Pending never holds bits that were not in the accepted mask.
- Reset asserted mid-sequence returns to IDLE with all outputs at reset values. No `done` pulse is produced for the aborted sequence.
- `stall` is ignored in IDLE and DONE. `done` is never stalled.

## Timing
- `start` is accepted at edge T. `busy` = 1 from cycle T+1.
- Serial mode, P = popcount(mask), no stall:
  - `triosy_lz` is one-hot in cycles T+1 .. T+P, ascending channel order.
  - `done` is high in cycle T+P+1.
  - `busy` = 0 and a new `start` can be accepted in cycle T+P+2.
- Each stalled ISSUE cycle adds exactly one cycle of latency.
- `ch_bawt[i]` rises in the cycle after `triosy_lz[i]`.
- Mask = 0: `done` is high in cycle T+1, with no `lz`.
- `triosy_lz` depends combinationally on `stall` in the same cycle. No other output has a combinational input path.

## Configuration
- `SDP_TRIOSY_SEQ_PARALLEL_EN` defined:
  - In ISSUE with `stall` = 0, `triosy_lz` = the full pending vector; pending clears and `ch_bawt` |= pending.
  - ISSUE always lasts one unstalled cycle: `done` is high at T+2 for any nonzero mask.
- Undefined: serial one-channel-per-cycle issue, as described above.

## Test plan
- Reset, then `start` with `ch_mask`=8'b1010_0100, no stall:
  - `lz` = 0x04 at T+1, 0x20 at T+2, 0x80 at T+3.
  - `done` at T+4, `ch_bawt` = 0xA4, `busy` low at T+5.
- Same mask with `stall` high in T+2 and T+3: `lz` 0x20 moves to T+4, 0x80 to T+5, `done` at T+6.
- `ch_mask` = 0: no `lz`, `done` at T+1, `ch_bawt` stays 0.
- Three `start` pulses during a busy sequence: `drop_cnt` = 3. Then 300 dropped starts with `DROP_W`=8: `drop_cnt` = 255.
- Reset asserted at T+2 of an 8-channel sequence: next cycle state IDLE, `lz` = 0, `ch_bawt` = 0, no `done` pulse.
- With `SDP_TRIOSY_SEQ_PARALLEL_EN` and `ch_mask` = 0xFF: `lz` = 0xFF in a single cycle at T+1, `done` at T+2. With `stall` high at T+1: `lz` at T+2, `done` at T+3.
